rx_stream_pack64: RTL and testbench

- Downstream of the PCS receive stream (32-bit data, 2-bit valid-byte code, valid, last, user); that stream has no ready.
- Packs pairs of 32-bit beats into a 64-bit AXI-stream word with tkeep, the format consumed by 64-bit MAC/user logic.
- Buffers whole frames in a store-and-forward FIFO so output backpressure never stalls the non-stallable input.
- Frames that do not fit are dropped whole and counted.

---
 rtl/pcs_stream_pkg.sv | 40 ++++
 rtl/pkt_commit_fifo.sv | 62 ++++++
 rtl/rx_stream_pack64.sv | 136 +++++++++++++
 tb/tb_rx_stream_pack64.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_stream_pkg.sv
// Types and helpers shared by the 32-to-64 bit PCS receive packer and its
// store-and-forward frame FIFO.
package pcs_stream_pkg;

    localparam logic PH_LO_ENC  = 1'b0;
    localparam logic PH_HI_ENC  = 1'b1;
    localparam logic NORMAL_ENC = 1'b0;
    localparam logic DROP_ENC   = 1'b1;

    typedef enum logic { PH_LO = PH_LO_ENC, PH_HI = PH_HI_ENC } phase_t;
    typedef enum logic { NORMAL = NORMAL_ENC, DROP = DROP_ENC } drop_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } entry_t;

    function automatic logic [3:0] vldb2mask(input logic [1:0] vldb);
        logic [3:0] mask;
        case (vldb)
            2'd0:    mask = 4'h1;
            2'd1:    mask = 4'h3;
            2'd2:    mask = 4'h7;
            default: mask = 4'hF;
        endcase
        return mask;
    endfunction

    // Bytes outside the mask are forced to zero so stale lane data never leaks out.
    function automatic logic [31:0] mask_bytes(input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/pkt_commit_fifo.sv
// Frame FIFO with a speculative write pointer: words become visible only once
// their frame's last word is committed, and a partial frame can be rewound.
module pkt_commit_fifo
    import pcs_stream_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   wr_en_i,
    input  logic   wr_commit_i,
    input  entry_t wr_entry_i,
    input  logic   rewind_i,
    output logic   full_o,
    output logic   rd_valid_o,
    output entry_t rd_entry_o,
    input  logic   rd_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

    logic [AW:0] wr_ptr;
    logic [AW:0] commit_ptr;
    logic [AW:0] rd_ptr;
    logic        rd_fire;
    entry_t      mem [DEPTH];

    // Full looks only at registered pointers, so a same-cycle read frees nothing.
    assign full_o     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign rd_valid_o = rd_ptr != commit_ptr;
    assign rd_entry_o = mem[rd_ptr[AW-1:0]];
    assign rd_fire    = rd_valid_o & rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
        end else begin
            if (rewind_i) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en_i) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (wr_commit_i) begin
                    commit_ptr <= wr_ptr + PTR_ONE;
                end
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_stream_pack64.sv
// Packs the non-stallable 32-bit PCS receive stream into 64-bit AXI-stream
// words, buffering whole frames and dropping any frame that cannot fit.
module rx_stream_pack64
    import pcs_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_valid_i,
    input  logic [31:0]      s_data_i,
    input  logic [1:0]       s_vldb_i,
    input  logic             s_last_i,
    input  logic             s_user_i,
    output logic             m_axis_tvalid_o,
    output logic [63:0]      m_axis_tdata_o,
    output logic [7:0]       m_axis_tkeep_o,
    output logic             m_axis_tlast_o,
    output logic             m_axis_tuser_o,
    input  logic             m_axis_tready_i,
    output logic             frame_drop_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    phase_t           phase_q, phase_d;
    drop_state_t      state_q, state_d;
    logic [31:0]      lo_q, lo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;

    entry_t      wr_entry;
    entry_t      rd_entry;
    logic        wr_en;
    logic        wr_commit;
    logic        rewind;
    logic        full;
    logic [3:0]  mask;
    logic [31:0] data_masked;

    assign mask        = vldb2mask(s_vldb_i);
    assign data_masked = mask_bytes(s_data_i, s_last_i ? mask : 4'hF);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_LO;
            state_q <= NORMAL;
            lo_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            state_q <= state_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        state_d   = state_q;
        lo_d      = lo_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        wr_en     = 1'b0;
        wr_commit = 1'b0;
        rewind    = 1'b0;

        if (phase_q == PH_LO) begin
            wr_entry.data = {32'h0, data_masked};
            wr_entry.keep = {4'h0, mask};
        end else begin
            wr_entry.data = {data_masked, lo_q};
            wr_entry.keep = {(s_last_i ? mask : 4'hF), 4'hF};
        end
        wr_entry.last = s_last_i;
        wr_entry.user = s_last_i & (err_q | s_user_i);

        if (s_valid_i) begin
            if (state_q == DROP || (phase_q != PH_LO || s_last_i) && full) begin
                // Overflow or an already-doomed frame: discard until its last beat.
                if (state_q == NORMAL) begin
                    rewind = 1'b1;
                end
                if (s_last_i) begin
                    drop_d  = 1'b1;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
                    state_d = NORMAL;
                    phase_d = PH_LO;
                    err_d   = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end else if (phase_q == PH_LO && !s_last_i) begin
                lo_d    = s_data_i;
                phase_d = PH_HI;
                err_d   = err_q | s_user_i;
            end else begin
                wr_en     = 1'b1;
                wr_commit = s_last_i;
                phase_d   = PH_LO;
                err_d     = s_last_i ? 1'b0 : (err_q | s_user_i);
            end
        end
    end

    pkt_commit_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en),
        .wr_commit_i (wr_commit),
        .wr_entry_i  (wr_entry),
        .rewind_i    (rewind),
        .full_o      (full),
        .rd_valid_o  (m_axis_tvalid_o),
        .rd_entry_o  (rd_entry),
        .rd_ready_i  (m_axis_tready_i)
    );

    assign m_axis_tdata_o = rd_entry.data;
    assign m_axis_tkeep_o = rd_entry.keep;
    assign m_axis_tlast_o = rd_entry.last;
    assign m_axis_tuser_o = rd_entry.user;
    assign frame_drop_o   = drop_q;
    assign drop_cnt_o     = cnt_q;

endmodule

// File: tb/tb_rx_stream_pack64.sv
// Directed bench for the 32-to-64 bit receive packer: a deep instance checks
// byte-exact delivery, a shallow instance checks whole-frame dropping.
`timescale 1ns/1ps
module tb_rx_stream_pack64;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic [1:0]  s_vldb;
    logic        s_last;
    logic        s_user;

    logic        rdy_a, tvalid_a, tlast_a, tuser_a, drop_a;
    logic [63:0] tdata_a;
    logic [7:0]  tkeep_a;
    logic [15:0] cnt_a;

    logic        rdy_b, tvalid_b, tlast_b, tuser_b, drop_b;
    logic [63:0] tdata_b;
    logic [7:0]  tkeep_b;
    logic [15:0] cnt_b;

    int    checks = 0;
    int    errors = 0;
    word_t rx_a[$];
    word_t exp_q[$];
    int    rx_total = 0;
    int    sent_words = 0;
    int    pulses_b = 0;
    logic  seen_valid_b = 1'b0;
    logic  pre_last_valid = 1'b0;
    logic  rand_ready = 1'b0;
    logic  stall_a = 1'b0;
    word_t held_a;

    rx_stream_pack64 #(.FIFO_DEPTH(64), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_vldb_i(s_vldb),
        .s_last_i(s_last), .s_user_i(s_user),
        .m_axis_tvalid_o(tvalid_a), .m_axis_tdata_o(tdata_a), .m_axis_tkeep_o(tkeep_a),
        .m_axis_tlast_o(tlast_a), .m_axis_tuser_o(tuser_a), .m_axis_tready_i(rdy_a),
        .frame_drop_o(drop_a), .drop_cnt_o(cnt_a)
    );

    rx_stream_pack64 #(.FIFO_DEPTH(8), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_vldb_i(s_vldb),
        .s_last_i(s_last), .s_user_i(s_user),
        .m_axis_tvalid_o(tvalid_b), .m_axis_tdata_o(tdata_b), .m_axis_tkeep_o(tkeep_b),
        .m_axis_tlast_o(tlast_b), .m_axis_tuser_o(tuser_b), .m_axis_tready_i(rdy_b),
        .frame_drop_o(drop_b), .drop_cnt_o(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Output monitor: collects accepted words and checks held words stay put while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                checkOutput("stall_hold", {5'b0, tvalid_a, tdata_a, tkeep_a, tlast_a, tuser_a},
                            {5'b0, 1'b1, held_a});
            end
            if (tvalid_a && rdy_a) begin
                rx_a.push_back({tdata_a, tkeep_a, tlast_a, tuser_a});
                rx_total++;
            end
            stall_a = tvalid_a && !rdy_a;
            held_a  = {tdata_a, tkeep_a, tlast_a, tuser_a};
            if (drop_b) pulses_b++;
            if (tvalid_b) seen_valid_b = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) rdy_a = ($urandom_range(0, 1) == 1);
    end

    // Byte k of a frame is base+k; unused lanes of the last beat carry junk.
    task automatic applyStimulus(input int nbytes, input int base, input int err_beat);
        int nbeats;
        int rem;
        logic [31:0] d;
        nbeats = (nbytes + 3) / 4;
        for (int i = 0; i < nbeats; i++) begin
            rem = nbytes - 4 * i;
            for (int b = 0; b < 4; b++) d[8*b +: 8] = (b < rem) ? 8'(base + 4 * i + b) : 8'hA5;
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == nbeats - 1);
            s_vldb  = s_last ? 2'(rem - 1) : 2'($urandom_range(0, 3));
            s_user  = (i == err_beat);
            if (s_last) begin
                @(negedge clk);
                pre_last_valid = tvalid_a;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        s_data  = '0;
        s_vldb  = '0;
    endtask

    task automatic addExpected(input int nbytes, input int base, input int err_beat);
        int    nw;
        word_t w;
        nw = (nbytes + 7) / 8;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int b = 0; b < 8; b++) begin
                if (8 * wi + b < nbytes) begin
                    w.data[8*b +: 8] = 8'(base + 8 * wi + b);
                    w.keep[b] = 1'b1;
                end
            end
            w.last = (wi == nw - 1);
            w.user = w.last && (err_beat >= 0);
            exp_q.push_back(w);
        end
    endtask

    task automatic waitDrain(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && rx_a.size() < n; c++) @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, 80'(rx_a.size()), 80'(n));
    endtask

    task automatic compareStream(input string tag);
        word_t r;
        word_t e;
        int    idx;
        idx = 0;
        while (exp_q.size() > 0 && rx_a.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_a.pop_front();
            checkOutput($sformatf("%s_w%0d", tag, idx), {6'b0, r}, {6'b0, e});
            idx++;
        end
        exp_q.delete();
        rx_a.delete();
    endtask

    initial begin
        int nb;
        int nw;
        int eb;
        int c;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_vldb = '0; s_last = 1'b0; s_user = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b0;
        #1;
        checkOutput("reset_tvalid_a", 80'(tvalid_a), 80'd0);
        checkOutput("reset_tvalid_b", 80'(tvalid_b), 80'd0);
        checkOutput("reset_drop", 80'({drop_a, drop_b}), 80'd0);
        checkOutput("reset_cnt", 80'({cnt_a, cnt_b}), 80'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] drop test on shallow instance");
        seen_valid_b = 1'b0;
        pulses_b = 0;
        applyStimulus(160, 8'h00, -1);
        addExpected(160, 8'h00, -1);
        checkOutput("drop_pulse_now", 80'(drop_b), 80'd1);
        @(posedge clk); #1;
        checkOutput("drop_pulse_once", 80'(pulses_b), 80'd1);
        checkOutput("drop_cnt_b", 80'(cnt_b), 80'd1);
        checkOutput("drop_no_valid", 80'(seen_valid_b), 80'd0);
        applyStimulus(8, 8'hC0, -1);
        addExpected(8, 8'hC0, -1);
        checkOutput("after_drop_word", {5'b0, tvalid_b, tdata_b, tkeep_b, tlast_b, tuser_b},
                    {5'b0, 1'b1, 64'hC7C6_C5C4_C3C2_C1C0, 8'hFF, 1'b1, 1'b0});
        rdy_b = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_drop_empty", 80'(tvalid_b), 80'd0);
        waitDrain("drop_deep", 21, 200);
        compareStream("drop_deep");

        $display("[TB] 70-byte frame");
        applyStimulus(70, 8'h00, -1);
        addExpected(70, 8'h00, -1);
        checkOutput("lat_before", 80'(pre_last_valid), 80'd0);
        checkOutput("lat_after", 80'(tvalid_a), 80'd1);
        waitDrain("f70", 9, 200);
        if (rx_a.size() >= 9) begin
            checkOutput("f70_first", {6'b0, rx_a[0]}, {6'b0, 64'h0706_0504_0302_0100, 8'hFF, 1'b0, 1'b0});
            checkOutput("f70_last", {6'b0, rx_a[8]}, {6'b0, 64'h0000_4544_4342_4140, 8'h3F, 1'b1, 1'b0});
        end
        compareStream("f70");

        $display("[TB] short frames 5/4/1 bytes");
        applyStimulus(5, 8'h10, -1);
        applyStimulus(4, 8'h20, -1);
        applyStimulus(1, 8'h30, -1);
        addExpected(5, 8'h10, -1);
        addExpected(4, 8'h20, -1);
        addExpected(1, 8'h30, -1);
        waitDrain("short", 3, 200);
        if (rx_a.size() >= 3) begin
            checkOutput("short_f1", {6'b0, rx_a[0]}, {6'b0, 64'h0000_0014_1312_1110, 8'h1F, 1'b1, 1'b0});
            checkOutput("short_f2", {6'b0, rx_a[1]}, {6'b0, 64'h0000_0000_2322_2120, 8'h0F, 1'b1, 1'b0});
            checkOutput("short_f3", {6'b0, rx_a[2]}, {6'b0, 64'h0000_0000_0000_0030, 8'h01, 1'b1, 1'b0});
        end
        compareStream("short");

        $display("[TB] error flag on beat 2 of 10");
        applyStimulus(40, 8'h40, 1);
        addExpected(40, 8'h40, 1);
        waitDrain("err", 5, 200);
        if (rx_a.size() >= 5) begin
            checkOutput("err_mid_user", 80'({rx_a[3].last, rx_a[3].user}), 80'd0);
            checkOutput("err_last_user", 80'({rx_a[4].last, rx_a[4].user}), 80'd3);
        end
        compareStream("err");

        $display("[TB] random frames with random ready");
        rx_total = 0;
        sent_words = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            nb = $urandom_range(1, 256);
            nw = (nb + 7) / 8;
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (nb + 3) / 4 - 1) : -1;
            for (c = 0; c < 2000 && (sent_words - rx_total + nw > 64); c++) begin
                @(posedge clk); #1;
            end
            if (sent_words - rx_total + nw > 64) begin
                checkOutput("throttle_timeout", 80'(sent_words - rx_total), 80'(64 - nw));
            end
            applyStimulus(nb, f * 7, eb);
            addExpected(nb, f * 7, eb);
            sent_words += nw;
        end
        waitDrain("rand", sent_words, 20000);
        rand_ready = 1'b0;
        @(posedge clk); #1;
        rdy_a = 1'b1;
        compareStream("rand");
        checkOutput("rand_no_drop", 80'(cnt_a), 80'd0);

        $display("[TB] asynchronous reset mid-frame");
        rdy_a = 1'b0;
        applyStimulus(12, 8'h60, -1);
        checkOutput("rst_pre_valid", 80'(tvalid_a), 80'd1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = {4{8'(8'h70 + i)}}; s_last = 1'b0; s_user = 1'b0;
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_tvalid", 80'(tvalid_a), 80'd0);
        checkOutput("rst_drop", 80'({drop_a, cnt_a}), 80'd0);
        s_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        rdy_a = 1'b1;
        rx_a.delete();
        exp_q.delete();
        @(posedge clk); #1;
        applyStimulus(72, 8'h80, -1);
        addExpected(72, 8'h80, -1);
        waitDrain("rst_frame", 9, 200);
        compareStream("rst_frame");
        checkOutput("rst_cnt_after", 80'(cnt_a), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
